ptp_ts_arbiter: RTL
===================

Name: ptp_ts_arbiter

Overview:
- Shares one timestamp queue between two ptp_parser instances: RX path (channel 0) and TX path (channel 1).
- Each parser emits a one-cycle found pulse with an info word {seqid, msgid[1:0], time}.
- This block captures each pulse into a per-channel holding register, arbitrates round-robin into a shared FIFO tagged with the channel, and presents the queue to the CPU register block.
- It counts events dropped on holding-register or queue overflow.

Parameters:
- INFOR_W, 48, width of parser info word.
- DEPTH, 16, FIFO entries; power of 2, minimum 2.
- AW, 4, log2(DEPTH).
- DROP_W, 8, width of each drop counter; counters saturate.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- rx_found  in  1  RX parser event pulse.
- rx_infor  in  INFOR_W  RX info; valid with rx_found.
- tx_found  in  1  TX parser event pulse.
- tx_infor  in  INFOR_W  TX info; valid with tx_found.
- q_rd  in  1  pop head entry.
- q_flush  in  1  empty FIFO and both holding registers.
- cnt_clr  in  1  clear both drop counters.
- q_data  out  INFOR_W+1  head entry {ch, infor}; ch=0 RX, ch=1 TX.
- q_empty  out  1  FIFO empty.
- q_level  out  AW+1  entries held, 0..DEPTH.
- rx_drop_cnt  out  DROP_W  RX events lost.
- tx_drop_cnt  out  DROP_W  TX events lost.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): FIFO empty, q_level=0, q_empty=1, q_data=0, both holding registers invalid, round-robin pointer=RX, drop counters=0. Reset overrides every other input.
- Capture: on a found pulse, info loads into that channel's holding register, which becomes valid.
  - If the register is already valid and is not being granted this same cycle, the new event is discarded and that channel's drop counter increments.
  - If it is being granted this cycle, the new event loads and the register stays valid, with no drop.
- Arbitration: evaluated every cycle from registered state.
  - Grant is allowed only if q_level < DEPTH. The full check ignores a same-cycle q_rd; no write-through when full.
  - Exactly one valid holding register is granted per cycle.
  - With both valid, the channel indicated by the pointer wins. After any grant, the pointer moves to the other channel.
  - The granted entry {ch, infor} is written at the wr pointer, and the holding register is invalidated unless refilled the same cycle.
- Latency: found at edge E0 → holding valid after E0 → FIFO write at E1 → q_empty=0 and q_data valid after E1. Minimum latency is 2 cycles. Under contention the losing channel waits 1 more cycle.
- Queue behaviour:
  - The queue is show-ahead: q_data always reflects the head entry when q_empty=0, and is 0 when empty.
  - q_rd pops at the edge. q_rd while empty is ignored, with no pointer or level change.
  - Simultaneous push and pop leaves q_level unchanged.
  - Pointers are AW bits and wrap modulo DEPTH.
  - q_level = pushes - pops and never exceeds DEPTH.
- Queue full: holding registers retain their entries and continue to absorb one event each. Further events on a full holding register are dropped and counted.
- q_flush:
  - Takes priority over capture, grant and pop in the same cycle. Pointers and level go to 0 and both holding registers are invalidated.
  - A found pulse in the flush cycle is discarded and not counted.
  - Drop counters and the rr pointer are not affected.
- Drop counters: saturate at all-ones. cnt_clr sets the counter to 0 and has priority over a same-cycle increment, which is lost.
- Simultaneous rx_found and tx_found are both captured in the same cycle, independently.

Optional Feature:
- Macro PTP_TS_ARB_FIXED_PRIO_EN.
- Defined: arbitration is strict priority with RX always winning. The rr pointer is not implemented. TX is granted only when RX holding is invalid.
- Undefined: round-robin as described above.

Test Plan:
- Single RX event: rx_found=1 with rx_infor=48'h1234_1_0ABCDEF pattern at E0 → after E1 q_empty=0, q_level=1, q_data={0, that value}. q_rd for 1 cycle → q_empty=1, q_data=0.
- Simultaneous rx_found and tx_found, pointer=RX → RX entry written at E1, TX at E2, q_level=2. Pop order is ch0 then ch1. Repeating the pair with the pointer now RX again (it toggled twice) gives the same order. Under PTP_TS_ARB_FIXED_PRIO_EN, RX first always.
- Fill DEPTH=16 with RX events and no reads, then 3 more rx_found pulses one per cycle:
  - q_level=16; the 17th event is held, 18th and 19th dropped; rx_drop_cnt=2.
  - One q_rd → held entry written next cycle, q_level=16.
- Back-to-back RX pulses on consecutive cycles with an empty queue → all captured (grant frees holding each cycle), rx_drop_cnt=0.
- q_flush with q_level=5 and TX holding valid → next cycle q_level=0, q_empty=1, no TX write follows, tx_drop_cnt unchanged.
- Drop-counter saturation: force 260 TX drops → tx_drop_cnt=255. Assert cnt_clr together with another drop → counter=0. Assert rst mid-stream with q_level=7 → all outputs return to reset values at the next edge.

Source files
------------

// File: rtl/ptp_ts_arbiter.sv
// Purpose : merges RX/TX ptp_parser timestamp events into one tagged show-ahead queue for the CPU.
// Latency : found pulse -> holding reg at E0, queue write at E1; contention loser waits one more cycle.
// Backpr. : queue full stalls grants; each holding reg absorbs one event, later events are dropped and counted.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   rx_found / rx_infor    RX parser event pulse and info word (channel 0)
//   tx_found / tx_infor    TX parser event pulse and info word (channel 1)
//   q_rd, q_flush          pop head entry / empty queue and both holding registers
//   cnt_clr                clear both drop counters
//   q_data, q_empty        head entry {ch, infor} (0 when empty), empty flag
//   q_level                entries held, 0..DEPTH
//   rx_drop_cnt/tx_drop_cnt saturating per-channel lost-event counters
//
// Build option: define PTP_TS_ARB_FIXED_PRIO_EN for strict RX-over-TX priority
// (no round-robin pointer); default build arbitrates round-robin.

module ptp_ts_arbiter #(
  parameter int INFOR_W = 48,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int DROP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_found,
  input  logic [INFOR_W-1:0] rx_infor,
  input  logic               tx_found,
  input  logic [INFOR_W-1:0] tx_infor,
  input  logic               q_rd,
  input  logic               q_flush,
  input  logic               cnt_clr,
  output logic [INFOR_W:0]   q_data,
  output logic               q_empty,
  output logic [AW:0]        q_level,
  output logic [DROP_W-1:0]  rx_drop_cnt,
  output logic [DROP_W-1:0]  tx_drop_cnt
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic               rx_hold_vld;
  logic               tx_hold_vld;
  logic [INFOR_W-1:0] rx_hold_dat;
  logic [INFOR_W-1:0] tx_hold_dat;

  logic [INFOR_W:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;

  logic               q_full;
  logic               gnt_rx;
  logic               gnt_tx;
  logic               push;
  logic               pop;
  logic [INFOR_W:0]   push_dat;
  logic               rx_drop;
  logic               tx_drop;

  assign q_full  = (q_level == LVL_FULL);
  assign q_empty = (q_level == '0);

  // Grant decision uses registered state only; a same-cycle pop does not
  // open a slot, so there is no write-through when the queue is full.
`ifdef PTP_TS_ARB_FIXED_PRIO_EN
  assign gnt_rx = rx_hold_vld && !q_full;
  assign gnt_tx = tx_hold_vld && !rx_hold_vld && !q_full;
`else
  logic rr_ptr;  // 0: RX wins a tie, 1: TX wins a tie

  assign gnt_rx = !q_full && rx_hold_vld && (!tx_hold_vld || !rr_ptr);
  assign gnt_tx = !q_full && tx_hold_vld && (!rx_hold_vld ||  rr_ptr);

  // A grant suppressed by flush never happened, so the pointer holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (push && !q_flush) begin
      rr_ptr <= gnt_rx;
    end
  end
`endif

  assign push     = gnt_rx || gnt_tx;
  assign pop      = q_rd && !q_empty;
  assign push_dat = gnt_tx ? {1'b1, tx_hold_dat} : {1'b0, rx_hold_dat};

  // An event is lost only when its holding reg stays occupied this cycle;
  // events arriving during a flush are discarded silently.
  assign rx_drop = rx_found && rx_hold_vld && !gnt_rx && !q_flush;
  assign tx_drop = tx_found && tx_hold_vld && !gnt_tx && !q_flush;

  assign q_data = q_empty ? '0 : mem[rd_ptr];

  // Holding registers: a grant frees the slot in the same cycle, so a new
  // pulse may refill it without a drop.
  always_ff @(posedge clk) begin
    if (rst || q_flush) begin
      rx_hold_vld <= 1'b0;
      tx_hold_vld <= 1'b0;
      if (rst) begin
        rx_hold_dat <= '0;
        tx_hold_dat <= '0;
      end
    end else begin
      if (rx_found && (!rx_hold_vld || gnt_rx)) begin
        rx_hold_vld <= 1'b1;
        rx_hold_dat <= rx_infor;
      end else if (gnt_rx) begin
        rx_hold_vld <= 1'b0;
      end
      if (tx_found && (!tx_hold_vld || gnt_tx)) begin
        tx_hold_vld <= 1'b1;
        tx_hold_dat <= tx_infor;
      end else if (gnt_tx) begin
        tx_hold_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !q_flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || q_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_level <= q_level + 1'b1;
        2'b01:   q_level <= q_level - 1'b1;
        default: q_level <= q_level;
      endcase
    end
  end

  // Clear beats a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      rx_drop_cnt <= '0;
      tx_drop_cnt <= '0;
    end else begin
      if (rx_drop && (rx_drop_cnt != '1)) rx_drop_cnt <= rx_drop_cnt + 1'b1;
      if (tx_drop && (tx_drop_cnt != '1)) tx_drop_cnt <= tx_drop_cnt + 1'b1;
    end
  end

endmodule
